fp_mult_pipe: RTL
=================

Name: fp_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point multiplier; successor to the combinational single-precision multiplier.
- Widths are configurable: FP32 by default, FP16/bfloat16 by parameter.
- Three-stage pipeline with valid/ready handshake and full backpressure.
- Correct round-to-nearest-even (guard/round/sticky), signed zero/infinity, quiet-NaN canonicalisation, per-result exception flags.
- Sits between the operand-issue logic and the FPU writeback arbiter.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit excluded).
- Derived: W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- opd1  in  W  operand A
- opd2  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- res  out  W  product
- nan  out  1  result is NaN (invalid op or NaN input)
- exp_overflow  out  1  finite operands overflowed to infinity
- underflow  out  1  nonzero finite result flushed to zero
- zero  out  1  result is (signed) zero
- inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Reset (rst=1 at a clock edge):
  - all stage valid bits cleared; out_valid=0; res=0; all flags 0.
  - In-flight operations are discarded; rst overrides any handshake in the same cycle.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - On stall every stage holds: no register changes, res and flags stable.
  - Bubbles are not collapsed.
  - Latency is exactly 3 cycles with out_ready=1; throughput is 1 op/cycle.
- Stage 1 (unpack/classify):
  - Split sign/exponent/fraction; sign_res = sign1 ^ sign2.
  - Class per operand: zero (exp=0, any fraction; subnormals flushed to zero), inf (exp all-ones, frac=0), NaN (exp all-ones, frac!=0), normal.
  - Exponent sum in EXP_W+2-bit signed arithmetic: e = e1 + e2 - bias.
- Stage 2 (multiply): product of {1,frac1} x {1,frac2}, 2*(MAN_W+1) bits.
- Stage 3 (normalise/round/pack):
  - If product MSB is set: shift right 1, e+1.
  - Keep MAN_W+1 bits; guard = next bit, sticky = OR of all lower bits, round bit folded into sticky.
  - RNE: increment when guard & (sticky | lsb).
  - Mantissa carry-out on rounding: shift right 1, e+1.
  - inexact = guard | sticky.
- Exception priority (highest first):
  1. Any NaN input, or zero x inf: res = canonical qNaN {0, all-ones, 1 followed by zeros}; nan=1; other flags 0.
  2. Any inf input: res = {sign_res, all-ones, 0}; exp_overflow=0.
  3. Any zero input: res = {sign_res, 0, 0}; zero=1.
  4. e >= 2^EXP_W-1 after rounding: res = {sign_res, all-ones, 0}; exp_overflow=1; inexact=1.
  5. e <= 0 after rounding: res = {sign_res, 0, 0}; underflow=1; zero=1; inexact=1.
  6. Otherwise: res = {sign_res, e[EXP_W-1:0], rounded fraction}.
- Flags are registered alongside res and are valid only while out_valid=1.

Test Plan:
- FP32 0x3FC00000 x 0x40000000, out_ready=1 -> 3 cycles later res=0x40400000, all flags 0.
- RNE tie: 0x3FC00000 x 0x3F800001 -> res=0x3FC00002, inexact=1. Sign: 0xBF800000 x 0x3F800000 -> res=0xBF800000.
- Overflow: 0x7F000000 x 0x40000000 -> res=0x7F800000, exp_overflow=1. Underflow: 0x00800000 x 0x3F000000 -> res=0x00000000, underflow=1, zero=1.
- Specials:
  - 0x7F800000 x 0x00000000 -> res=0x7FC00000, nan=1.
  - 0xFF800000 x 0x40000000 -> res=0xFF800000, exp_overflow=0.
  - 0x80000000 x 0x3F800000 -> res=0x80000000, zero=1.
- Backpressure: stream 5 ops back-to-back with out_ready=0 from cycle 2 -> in_ready drops once the first result is valid, res held stable; on release results emerge in order with no loss or duplication. Assert rst mid-stream -> out_valid=0 on the next cycle, no stale outputs.
- Parametrised FP16 (EXP_W=5, MAN_W=10): 0x3E00 x 0x4000 -> 0x4200; 0x7800 x 0x4000 -> 0x7C00 with exp_overflow=1.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (FP32 default, FP16/bf16 by parameter).
// RNE rounding, subnormals flushed to zero, canonical qNaN, per-result flags.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   opd1,
  input  logic [EXP_W+MAN_W:0]   opd2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   nan,
  output logic                   exp_overflow,
  output logic                   underflow,
  output logic                   zero,
  output logic                   inexact
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 1;
  localparam int PW     = 2 * MW;
  localparam int EW     = EXP_W + 2;
  localparam int STAGES = 3;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic          stall;
  logic [STAGES:1] vld_q;

  assign stall     = vld_q[STAGES] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[STAGES];

  always_ff @(posedge clk) begin
    if (rst)         vld_q <= '0;
    else if (!stall) vld_q <= {vld_q[STAGES-1:1], in_valid};
  end

  // ---- stage 1: unpack / classify ----
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, ia, ib, na, nb;
  logic             sgn_d, nan_c_d, inf_c_d, zer_c_d;
  logic [EW-1:0]    e1_d;

  always_comb begin
    ea = opd1[W-2:MAN_W];
    eb = opd2[W-2:MAN_W];
    fa = opd1[MAN_W-1:0];
    fb = opd2[MAN_W-1:0];
    za = (ea == '0);
    zb = (eb == '0);
    ia = (&ea) & (fa == '0);
    ib = (&eb) & (fb == '0);
    na = (&ea) & (|fa);
    nb = (&eb) & (|fb);
    sgn_d   = opd1[W-1] ^ opd2[W-1];
    nan_c_d = na | nb | (za & ib) | (ia & zb);
    inf_c_d = ia | ib;
    zer_c_d = za | zb;
    e1_d    = {2'b00, ea} + {2'b00, eb} - BIAS;
  end

  logic          sgn1_q, nan1_q, inf1_q, zer1_q;
  logic [EW-1:0] e1_q;
  logic [MW-1:0] m1_q, m2_q;

  always_ff @(posedge clk) begin
    if (!stall) begin
      sgn1_q <= sgn_d;
      nan1_q <= nan_c_d;
      inf1_q <= inf_c_d;
      zer1_q <= zer_c_d;
      e1_q   <= e1_d;
      m1_q   <= {1'b1, fa};
      m2_q   <= {1'b1, fb};
    end
  end

  // ---- stage 2: significand multiply ----
  logic [PW-1:0] prod_d;
  assign prod_d = {{MW{1'b0}}, m1_q} * {{MW{1'b0}}, m2_q};

  logic          sgn2_q, nan2_q, inf2_q, zer2_q;
  logic [EW-1:0] e2_q;
  logic [PW-1:0] prod_q;

  always_ff @(posedge clk) begin
    if (!stall) begin
      sgn2_q <= sgn1_q;
      nan2_q <= nan1_q;
      inf2_q <= inf1_q;
      zer2_q <= zer1_q;
      e2_q   <= e1_q;
      prod_q <= prod_d;
    end
  end

  // ---- stage 3: normalise, round, pack ----
  logic          msb, guard, sticky, inc;
  logic [PW-1:0] norm;
  logic [MW-1:0] mant;
  logic [MW:0]   rnd;
  logic [EW-1:0] e_n;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]  res_d;
  logic          nan_d, ovf_d, unf_d, zero_d, inx_d;

  always_comb begin
    msb    = prod_q[PW-1];
    norm   = msb ? prod_q : (prod_q << 1);
    mant   = norm[PW-1 -: MW];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    inc    = guard & (sticky | mant[0]);
    rnd    = {1'b0, mant} + {{MW{1'b0}}, inc};
    // Normalisation shift and rounding carry each bump the exponent by one.
    e_n    = e2_q + {{(EW-1){1'b0}}, msb} + {{(EW-1){1'b0}}, rnd[MW]};
    frac   = rnd[MW] ? rnd[MW-1:1] : rnd[MAN_W-1:0];

    res_d  = {sgn2_q, e_n[EXP_W-1:0], frac};
    nan_d  = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = 1'b0;
    inx_d  = guard | sticky;

    if (nan2_q) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      nan_d = 1'b1;
      inx_d = 1'b0;
    end else if (inf2_q) begin
      res_d = {sgn2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      inx_d = 1'b0;
    end else if (zer2_q) begin
      res_d  = {sgn2_q, {(W-1){1'b0}}};
      zero_d = 1'b1;
      inx_d  = 1'b0;
    end else if (!e_n[EW-1] && (e_n >= EMAX)) begin
      res_d = {sgn2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e_n[EW-1] || (e_n == '0)) begin
      res_d  = {sgn2_q, {(W-1){1'b0}}};
      unf_d  = 1'b1;
      zero_d = 1'b1;
      inx_d  = 1'b1;
    end
  end

  logic [W-1:0] res_q;
  logic         nan_q, ovf_q, unf_q, zero_q, inx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      nan_q  <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      zero_q <= 1'b0;
      inx_q  <= 1'b0;
    end else if (!stall) begin
      res_q  <= res_d;
      nan_q  <= nan_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      zero_q <= zero_d;
      inx_q  <= inx_d;
    end
  end

  assign res          = res_q;
  assign nan          = nan_q;
  assign exp_overflow = ovf_q;
  assign underflow    = unf_q;
  assign zero         = zero_q;
  assign inexact      = inx_q;

endmodule
